// File: rtl/tx_frame_control_if.sv
// tx_frame_control_if: FIFO pop side and MAC/PHY byte side of the transmit controller.
// The controller connects to master; the FIFO/MAC environment connects to slave.
interface tx_frame_control_if;
    logic       empty;
    logic [7:0] din;
    logic       din_last;
    logic       rd_en;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_er;
    logic       done_out;
    logic       frame_bad;

    modport master (
        input  empty, din, din_last,
        output rd_en, tx_data, tx_en, tx_er, done_out, frame_bad
    );

    modport slave (
        output empty, din, din_last,
        input  rd_en, tx_data, tx_en, tx_er, done_out, frame_bad
    );
endinterface

// File: rtl/tx_frame_control.sv
// tx_frame_control: frames FIFO bytes as preamble+SFD+data[+pad]+FCS and enforces the IFG.
// Define TX_FRAME_PAD_EN to zero-pad short frames up to MIN_FRAME.
module tx_frame_control #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514,
    parameter int IFG_BYTES    = 12
) (
    input  logic               clk,
    input  logic               reset,
    tx_frame_control_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
`ifdef TX_FRAME_PAD_EN
        PAD,
`endif
        FCS,
        DRAIN,
        IFG
    } state_t;

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [7:0]  r_aux;
    logic [31:0] r_crc;
    logic        r_bad;
    logic        r_drain;
    logic [7:0]  r_tx_data;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_done;
    logic        r_fbad;

    logic        w_pop;
    logic [10:0] w_cnt_nxt;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign w_pop      = (r_state == DATA || r_state == DRAIN) && !bus.empty;
    assign w_cnt_nxt  = (r_cnt == 11'(MAX_FRAME)) ? r_cnt : r_cnt + 11'd1;
    // a bad frame sends the raw register, i.e. the complement of the normal FCS
    assign w_fcs      = r_bad ? r_crc : ~r_crc;
    assign w_fcs_byte = 8'(w_fcs >> {r_aux[1:0], 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_aux     <= '0;
            r_crc     <= '1;
            r_bad     <= 1'b0;
            r_drain   <= 1'b0;
            r_tx_data <= '0;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_done    <= 1'b0;
            r_fbad    <= 1'b0;
        end else begin
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_done    <= 1'b0;
            r_fbad    <= 1'b0;
            if (r_state == IDLE || r_state == IFG) begin
                r_cnt   <= '0;
                r_crc   <= '1;
                r_bad   <= 1'b0;
                r_drain <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_aux <= '0;
                    if (!bus.empty) r_state <= PREAMBLE;
                end
                PREAMBLE: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= 8'h55;
                    if (r_aux == 8'(PREAMBLE_LEN - 1)) begin
                        r_aux   <= '0;
                        r_state <= SFD;
                    end else begin
                        r_aux <= r_aux + 8'd1;
                    end
                end
                SFD: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= 8'hD5;
                    r_state   <= DATA;
                end
                DATA: begin
                    r_tx_en <= 1'b1;
                    if (bus.empty) begin
                        r_tx_er <= 1'b1;
                        r_bad   <= 1'b1;
                    end else begin
                        r_tx_data <= bus.din;
                        r_crc     <= crc_byte(r_crc, bus.din);
                        r_cnt     <= w_cnt_nxt;
                        if (bus.din_last) begin
`ifdef TX_FRAME_PAD_EN
                            r_state <= (w_cnt_nxt < 11'(MIN_FRAME)) ? PAD : FCS;
`else
                            r_state <= FCS;
`endif
                        end else if (w_cnt_nxt == 11'(MAX_FRAME)) begin
                            r_bad   <= 1'b1;
                            r_drain <= 1'b1;
                            r_state <= FCS;
                        end
                    end
                end
`ifdef TX_FRAME_PAD_EN
                PAD: begin
                    r_tx_en <= 1'b1;
                    r_crc   <= crc_byte(r_crc, 8'h00);
                    r_cnt   <= w_cnt_nxt;
                    if (w_cnt_nxt == 11'(MIN_FRAME)) r_state <= FCS;
                end
`endif
                FCS: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= w_fcs_byte;
                    if (r_aux[1:0] == 2'd3) begin
                        r_done  <= 1'b1;
                        r_fbad  <= r_bad;
                        r_aux   <= '0;
                        r_state <= r_drain ? DRAIN : IFG;
                    end else begin
                        r_aux <= r_aux + 8'd1;
                    end
                end
                // drain cycles already count toward the gap
                DRAIN: begin
                    if (r_aux < 8'(IFG_BYTES - 1)) r_aux <= r_aux + 8'd1;
                    if (w_pop && bus.din_last) r_state <= IFG;
                end
                IFG: begin
                    if (r_aux >= 8'(IFG_BYTES - 1)) begin
                        r_aux   <= '0;
                        r_state <= bus.empty ? IDLE : PREAMBLE;
                    end else begin
                        r_aux <= r_aux + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en     = w_pop;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_en     = r_tx_en;
    assign bus.tx_er     = r_tx_er;
    assign bus.done_out  = r_done;
    assign bus.frame_bad = r_fbad;
endmodule
